// File: rtl/ram_bank_32x16.sv
// ram_bank_32x16: single-port 32x16 synchronous RAM with post-reset init sweep and registered read
module ram_bank_32x16 #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 5,
  parameter int INIT_MODE = 0,
  parameter logic [DATA_W-1:0] INIT_VALUE = '0
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic [ADDR_W-1:0] Address,
  input  logic [DATA_W-1:0] DataIN,
  input  logic              ReadEnable,
  input  logic              WriteEnable,
  output logic [DATA_W-1:0] DataOut,
  output logic              DataValid,
  output logic              MemReady,
  output logic              AccessErr
);
  localparam int DEPTH = 2 ** ADDR_W;
  typedef enum logic {INIT, SERVE} state_t;
  state_t state, state_nx;
  logic [ADDR_W-1:0] ptr;
  logic [DATA_W-1:0] mem [DEPTH];
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic [DATA_W-1:0] fill;
  always_comb begin
    state_nx = (state == INIT && ptr == ADDR_W'(DEPTH - 1)) ? SERVE : state;
    fill = (INIT_MODE == 1) ? DATA_W'(ptr) : INIT_VALUE;
    wr_en = Reset && (state == INIT || WriteEnable);
    wr_addr = (state == INIT) ? ptr : Address;
    wr_data = (state == INIT) ? fill : DataIN;
  end
  // Array has no reset; the sweep rewrites every word before MemReady rises.
  always_ff @(posedge Clock)
    if (wr_en) mem[wr_addr] <= wr_data;
  always_ff @(posedge Clock) begin
    if (!Reset) begin
      state <= INIT;
      ptr <= '0;
      DataOut <= '0;
      DataValid <= 1'b0;
      AccessErr <= 1'b0;
    end else begin
      state <= state_nx;
      if (state == INIT) ptr <= ptr + 1'b1;
      DataValid <= (state == SERVE) && ReadEnable;
      if (state == SERVE && ReadEnable) DataOut <= mem[Address];
      if (state == INIT && (ReadEnable || WriteEnable)) AccessErr <= 1'b1;
    end
  end
  assign MemReady = (state == SERVE);
endmodule

// File: tb/tb_ram_bank_32x16.sv
// tb_ram_bank_32x16: scoreboard bench driving two RAM configurations (index fill, A5A5 fill) in lockstep
module tb_ram_bank_32x16;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n, re, we;
  logic [4:0] addr;
  logic [15:0] din;
  logic [15:0] dout_a, dout_b;
  logic dv_a, dv_b, rdy_a, rdy_b, err_a, err_b;
  ram_bank_32x16 #(.DATA_W(16), .ADDR_W(5), .INIT_MODE(1), .INIT_VALUE(16'h0)) dut_a (
    .Clock(clk), .Reset(rst_n), .Address(addr), .DataIN(din), .ReadEnable(re),
    .WriteEnable(we), .DataOut(dout_a), .DataValid(dv_a), .MemReady(rdy_a), .AccessErr(err_a));
  ram_bank_32x16 #(.DATA_W(16), .ADDR_W(5), .INIT_MODE(0), .INIT_VALUE(16'hA5A5)) dut_b (
    .Clock(clk), .Reset(rst_n), .Address(addr), .DataIN(din), .ReadEnable(re),
    .WriteEnable(we), .DataOut(dout_b), .DataValid(dv_b), .MemReady(rdy_b), .AccessErr(err_b));
  int errors = 0, checks = 0, cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;
  typedef struct {logic [15:0] a; logic [15:0] b; int c;} exp_t;
  exp_t q[$];
  exp_t e;
  logic [15:0] ma [32];
  logic [15:0] mb [32];
  bit m_ready = 0, m_err = 0;
  int sweep = 0;
  task automatic chk(string name, logic [31:0] act, logic [31:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%h want=%h", name, cyc, act, want);
    end
  endtask
  // Monitor: every valid pulse must match the oldest outstanding read, on the cycle it is due.
  always @(negedge clk) begin
    if (dv_a === 1'b1 || dv_b === 1'b1 || (q.size() > 0 && q[0].c <= cyc)) begin
      if (q.size() == 0) chk("spurious_valid", {30'd0, dv_a, dv_b}, 32'd0);
      else begin
        e = q.pop_front();
        chk("valid_timing", {30'd0, dv_a, dv_b}, 32'd3);
        chk("dout_a", {16'd0, dout_a}, {16'd0, e.a});
        chk("dout_b", {16'd0, dout_b}, {16'd0, e.b});
      end
    end
  end
  task automatic go(bit r, bit r_e, bit w_e, int a, logic [15:0] d);
    rst_n = r; re = r_e; we = w_e; addr = 5'(a); din = d;
    if (!r) begin
      m_ready = 0; m_err = 0; sweep = 0;
    end else if (!m_ready) begin
      if (r_e || w_e) m_err = 1;
      sweep++;
      if (sweep == 32) begin
        m_ready = 1;
        for (int i = 0; i < 32; i++) begin ma[i] = 16'(i); mb[i] = 16'hA5A5; end
      end
    end else begin
      if (r_e) q.push_back('{ma[a], mb[a], cyc + 1});
      if (w_e) begin ma[a] = d; mb[a] = d; end
    end
    @(posedge clk); #1;
    chk("mem_ready", {30'd0, rdy_a, rdy_b}, {30'd0, m_ready, m_ready});
    chk("access_err", {30'd0, err_a, err_b}, {30'd0, m_err, m_err});
    if (!r) chk("reset_dout", {dout_a, dout_b}, 32'd0);
  endtask
  task automatic idle(int n);
    for (int i = 0; i < n; i++) go(1, 0, 0, 0, 16'h0);
  endtask
  task automatic read_all();
    for (int i = 0; i < 32; i++) go(1, 1, 0, i, 16'h0);
    idle(2);
  endtask
  task automatic random_ops(int n);
    for (int i = 0; i < n; i++)
      go(1, $urandom_range(0, 2) == 0, $urandom_range(0, 2) == 0, $urandom_range(0, 31), 16'($urandom));
    idle(2);
  endtask
  initial begin
    rst_n = 0; re = 0; we = 0; addr = 0; din = 0;
    go(0, 0, 0, 0, 0); go(0, 0, 0, 0, 0);
    idle(32);
    read_all();
    go(1, 0, 1, 5, 16'hBEEF); go(1, 1, 0, 5, 0); idle(2);
    go(1, 0, 1, 9, 16'h1111); go(1, 1, 1, 9, 16'h2222); go(1, 1, 0, 9, 0); idle(2);
    random_ops(200);
    go(0, 0, 0, 0, 0); go(0, 0, 0, 0, 0);
    idle(10); go(1, 1, 0, 3, 0); idle(21);
    read_all();
    random_ops(50);
    idle(20);
    go(0, 0, 0, 0, 0); go(0, 0, 0, 0, 0);
    idle(32);
    read_all();
    random_ops(200);
    idle(3);
    chk("queue_drained", q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
